fir_sequencer: RTL and testbench

//  Autonomous FIR-tap controller in the DSP core. It sequences the dual-port data

---
 rtl/fir_sequencer_if.sv | 43 ++++
 rtl/fir_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fir_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sequencer_if.sv
// Start/config handshake plus dmem port A/B and MAC signals owned by fir_sequencer while busy.
interface fir_sequencer_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 7
);
    logic              start;
    logic [CNT_W-1:0]  cfg_ntaps;
    logic [ADDR_W-1:0] cfg_x_base;
    logic [ADDR_W-1:0] cfg_h_base;
    logic [ADDR_W-1:0] cfg_y_addr;
    logic [4:0]        cfg_shift;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] dmem_addr_a;
    logic              dmem_we_a;
    logic [31:0]       dmem_wdata_a;
    logic [31:0]       dmem_rdata_a;
    logic [ADDR_W-1:0] dmem_addr_b;
    logic [31:0]       dmem_rdata_b;

    logic [15:0]       mac_a;
    logic [15:0]       mac_b;
    logic              mac_en;
    logic              mac_clr;
    logic [31:0]       mac_acc;

    modport master (
        input  start, cfg_ntaps, cfg_x_base, cfg_h_base, cfg_y_addr, cfg_shift,
        input  dmem_rdata_a, dmem_rdata_b, mac_acc,
        output busy, done,
        output dmem_addr_a, dmem_we_a, dmem_wdata_a, dmem_addr_b,
        output mac_a, mac_b, mac_en, mac_clr
    );

    modport slave (
        output start, cfg_ntaps, cfg_x_base, cfg_h_base, cfg_y_addr, cfg_shift,
        output dmem_rdata_a, dmem_rdata_b, mac_acc,
        input  busy, done,
        input  dmem_addr_a, dmem_we_a, dmem_wdata_a, dmem_addr_b,
        input  mac_a, mac_b, mac_en, mac_clr
    );
endinterface

// File: rtl/fir_sequencer.sv
// Autonomous FIR tap sequencer: streams samples/coefficients from dmem into the MAC,
// then writes the shifted, saturated accumulator back to dmem port A.
module fir_sequencer #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned TAPS_MAX = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic            clk,
    input  logic            rst,
    fir_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] TAPS_MAX_C = CNT_W'(TAPS_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ntaps_q, ntaps_d;
    logic [ADDR_W-1:0] xb_q, xb_d;
    logic [ADDR_W-1:0] hb_q, hb_d;
    logic [ADDR_W-1:0] y_addr_q, y_addr_d;
    logic [4:0]        sh_q, sh_d;
    logic              zero_q, zero_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              we_a_q, we_a_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_clr_q, mac_clr_d;

    logic [CNT_W-1:0]  ntaps_clamped_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic signed [31:0] acc_shift_c;
    logic [15:0]       y_sat_c;
    logic [15:0]       y_c;
    logic              unused_rdata_hi;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ntaps_q   <= '0;
            xb_q      <= '0;
            hb_q      <= '0;
            y_addr_q  <= '0;
            sh_q      <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            we_a_q    <= 1'b0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ntaps_q   <= ntaps_d;
            xb_q      <= xb_d;
            hb_q      <= hb_d;
            y_addr_q  <= y_addr_d;
            sh_q      <= sh_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            we_a_q    <= we_a_d;
            mac_en_q  <= mac_en_d;
            mac_clr_q <= mac_clr_d;
        end
    end

    // Next state plus the registered outputs for the coming cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ntaps_d   = ntaps_q;
        xb_d      = xb_q;
        hb_d      = hb_q;
        y_addr_d  = y_addr_q;
        sh_d      = sh_q;
        zero_d    = zero_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        addr_a_d  = '0;
        addr_b_d  = '0;
        we_a_d    = 1'b0;
        mac_en_d  = 1'b0;
        mac_clr_d = 1'b0;

        ntaps_clamped_c = (bus.cfg_ntaps > TAPS_MAX_C) ? TAPS_MAX_C : bus.cfg_ntaps;
        cnt_inc_c       = cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ntaps_d  = ntaps_clamped_c;
                    xb_d     = bus.cfg_x_base;
                    hb_d     = bus.cfg_h_base;
                    y_addr_d = bus.cfg_y_addr;
                    sh_d     = bus.cfg_shift;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    if (ntaps_clamped_c != '0) begin
                        state_d  = S_FETCH;
                        zero_d   = 1'b0;
                        addr_a_d = bus.cfg_x_base;
                        addr_b_d = bus.cfg_h_base;
                    end else begin
                        // Empty filter: go straight to writing a zero result.
                        state_d  = S_WRITE;
                        zero_d   = 1'b1;
                        addr_a_d = bus.cfg_y_addr;
                        we_a_d   = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                busy_d    = 1'b1;
                mac_en_d  = 1'b1;
                mac_clr_d = (cnt_q == '0);
                if (cnt_inc_c == ntaps_q) begin
                    state_d = S_ACC;
                end else begin
                    cnt_d    = cnt_inc_c;
                    addr_a_d = xb_q - ADDR_W'(cnt_inc_c);
                    addr_b_d = hb_q + ADDR_W'(cnt_inc_c);
                end
            end
            S_ACC: begin
                state_d  = S_WRITE;
                busy_d   = 1'b1;
                we_a_d   = 1'b1;
                addr_a_d = y_addr_q;
            end
            S_WRITE: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift and saturate the registered MAC result during the write cycle.
    always_comb begin
        acc_shift_c = $signed(bus.mac_acc) >>> sh_q;
        if (acc_shift_c > 32'sd32767) begin
            y_sat_c = 16'h7FFF;
        end else if (acc_shift_c < -32'sd32768) begin
            y_sat_c = 16'h8000;
        end else begin
            y_sat_c = acc_shift_c[15:0];
        end
        y_c = zero_q ? 16'h0000 : y_sat_c;
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.dmem_addr_a  = addr_a_q;
    assign bus.dmem_addr_b  = addr_b_q;
    assign bus.dmem_we_a    = we_a_q;
    assign bus.mac_en       = mac_en_q;
    assign bus.mac_clr      = mac_clr_q;

    // Read data arrives one cycle after the address, so operands pass straight through.
    assign bus.mac_a        = mac_en_q ? bus.dmem_rdata_a[15:0] : 16'h0000;
    assign bus.mac_b        = mac_en_q ? bus.dmem_rdata_b[15:0] : 16'h0000;
    assign bus.dmem_wdata_a = we_a_q ? {{16{y_c[15]}}, y_c} : 32'h0;

    assign unused_rdata_hi  = ^{bus.dmem_rdata_a[31:16], bus.dmem_rdata_b[31:16]};

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: behavioural dmem/MAC around the DUT, spec vectors, corner sequences, random jobs.
module tb_fir_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_sequencer_if #(.ADDR_W(10), .CNT_W(7)) bus ();

    fir_sequencer #(.ADDR_W(10), .TAPS_MAX(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] mac_acc_r;
    logic signed [31:0] mac_prod;

    assign mac_prod = $signed({{16{bus.mac_a[15]}}, bus.mac_a}) * $signed({{16{bus.mac_b[15]}}, bus.mac_b});
    assign bus.mac_acc = mac_acc_r;

    // Synchronous dual-port memory and accumulating MAC environment.
    always @(posedge clk) begin
        bus.dmem_rdata_a <= mem[bus.dmem_addr_a];
        bus.dmem_rdata_b <= mem[bus.dmem_addr_b];
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (bus.dmem_we_a) mem[bus.dmem_addr_a] <= bus.dmem_wdata_a;
        if (bus.mac_en) mac_acc_r <= (bus.mac_clr ? 32'd0 : mac_acc_r) + mac_prod;
    end

    typedef struct {
        int          n;
        int          xb;
        int          hb;
        int          ya;
        int          sh;
        bit          use_model;
        logic [15:0] exp_y;
        int          exp_done;
    } vec_t;

    vec_t tab [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic write_mem(input int addr, input logic [31:0] data);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = 10'(addr);
        ld_data = data;
        ref_mem[addr & 1023] = data;
    endtask

    // Reference: plain signed sum of products, 32-bit wrap, arithmetic shift, saturate.
    function automatic logic [15:0] ref_y(input int n, input int xb, input int hb, input int sh);
        int np;
        longint acc;
        longint s;
        logic signed [31:0] a32;
        logic [15:0] xv;
        logic [15:0] hv;
        np  = (n > 64) ? 64 : n;
        acc = 0;
        for (int k = 0; k < np; k++) begin
            xv  = ref_mem[(xb - k) & 1023][15:0];
            hv  = ref_mem[(hb + k) & 1023][15:0];
            acc = acc + longint'($signed(xv)) * longint'($signed(hv));
        end
        a32 = acc[31:0];
        s   = longint'(a32) >>> sh;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    function automatic logic any_out();
        return |{bus.busy, bus.done, bus.dmem_addr_a, bus.dmem_we_a, bus.dmem_wdata_a,
                 bus.dmem_addr_b, bus.mac_a, bus.mac_b, bus.mac_en, bus.mac_clr};
    endfunction

    task automatic run_job(input string tag, input int n, input int xb, input int hb, input int ya,
                           input int sh, input logic [15:0] ey, input int exp_dn, input bit poke);
        int np;
        int wr_c;
        int got_wr_c = 0;
        int got_wr_n = 0;
        int got_dn_c = 0;
        int dn_cnt = 0;
        int en_cnt = 0;
        int clr_cnt = 0;
        int clr_c = 0;
        int ea;
        int eb;
        bit addr_ok = 1'b1;
        bit mac_ok = 1'b1;
        bit busy_ok = 1'b1;
        logic [15:0] ema;
        logic [15:0] emb;
        logic [31:0] got_wdata = 32'h0;
        logic [31:0] ew;
        np   = (n > 64) ? 64 : n;
        wr_c = exp_dn - 1;
        ew   = {{16{ey[15]}}, ey};
        @(negedge clk);
        bus.start      = 1'b1;
        bus.cfg_ntaps  = 7'(n);
        bus.cfg_x_base = 10'(xb);
        bus.cfg_h_base = 10'(hb);
        bus.cfg_y_addr = 10'(ya);
        bus.cfg_shift  = 5'(sh);
        for (int c = 1; c <= exp_dn + 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (poke && c < exp_dn) begin
                bus.cfg_ntaps  = 7'($urandom);
                bus.cfg_x_base = 10'($urandom);
                bus.cfg_h_base = 10'($urandom);
                bus.cfg_y_addr = 10'($urandom);
                bus.cfg_shift  = 5'($urandom);
            end
            if (poke && (c == 3 || c == 7 || c == exp_dn)) bus.start = 1'b1;
            if (bus.busy !== (c <= wr_c)) busy_ok = 1'b0;
            if (bus.done) begin
                dn_cnt++;
                if (got_dn_c == 0) got_dn_c = c;
            end
            if (bus.dmem_we_a) begin
                got_wr_n++;
                got_wr_c  = c;
                got_wdata = bus.dmem_wdata_a;
            end
            if (bus.mac_en) en_cnt++;
            if (bus.mac_clr) begin
                clr_cnt++;
                clr_c = c;
            end
            if (c <= np) begin
                ea = (xb - (c - 1)) & 1023;
                eb = (hb + (c - 1)) & 1023;
            end else if (c == wr_c) begin
                ea = ya & 1023;
                eb = 0;
            end else begin
                ea = 0;
                eb = 0;
            end
            if (bus.dmem_addr_a !== 10'(ea) || bus.dmem_addr_b !== 10'(eb)) addr_ok = 1'b0;
            if (c >= 2 && c <= np + 1) begin
                ema = ref_mem[(xb - (c - 2)) & 1023][15:0];
                emb = ref_mem[(hb + (c - 2)) & 1023][15:0];
            end else begin
                ema = 16'h0;
                emb = 16'h0;
            end
            if (bus.mac_a !== ema || bus.mac_b !== emb) mac_ok = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, " wr_cycle"}, 32'(got_wr_c), 32'(wr_c));
        check({tag, " wr_count"}, 32'(got_wr_n), 32'd1);
        check({tag, " wdata"}, got_wdata, ew);
        check({tag, " done_cycle"}, 32'(got_dn_c), 32'(exp_dn));
        check({tag, " done_count"}, 32'(dn_cnt), 32'd1);
        check({tag, " mac_en_cycles"}, 32'(en_cnt), 32'(np));
        check({tag, " mac_clr"}, {16'(clr_cnt), 16'(clr_c)}, (np == 0) ? 32'h0 : {16'd1, 16'd2});
        check({tag, " addr_seq_ok"}, 32'(addr_ok), 32'd1);
        check({tag, " mac_operands_ok"}, 32'(mac_ok), 32'd1);
        check({tag, " busy_ok"}, 32'(busy_ok), 32'd1);
        check({tag, " mem_y"}, mem[ya & 1023], ew);
        ref_mem[ya & 1023] = ew;
    endtask

    task automatic reset_mid_job();
        int we_cnt = 0;
        int dn_cnt = 0;
        int busy_cnt = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.cfg_ntaps  = 7'd8;
        bus.cfg_x_base = 10'd200;
        bus.cfg_h_base = 10'd100;
        bus.cfg_y_addr = 10'd910;
        bus.cfg_shift  = 5'd0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid outputs_zero", 32'(any_out()), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.dmem_we_a) we_cnt++;
            if (bus.done) dn_cnt++;
            if (bus.busy) busy_cnt++;
        end
        check("rst_mid no_write", 32'(we_cnt), 32'd0);
        check("rst_mid no_done", 32'(dn_cnt), 32'd0);
        check("rst_mid idle", 32'(busy_cnt), 32'd0);
        check("rst_mid mem_y_kept", mem[910], ref_mem[910]);
    endtask

    initial begin
        int n;
        int xb;
        int hb;
        int ya;
        int sh;
        int np;
        logic [15:0] ey;

        tab[0]  = '{4,   200, 100,  900, 0,  1'b0, 16'h012C, 7};
        tab[1]  = '{4,   1,   1022, 901, 3,  1'b1, 16'h0000, 7};
        tab[2]  = '{2,   300, 400,  902, 0,  1'b0, 16'h7FFF, 5};
        tab[3]  = '{2,   300, 400,  903, 16, 1'b0, 16'h7FFE, 5};
        tab[4]  = '{1,   500, 600,  904, 0,  1'b0, 16'hFF9C, 4};
        tab[5]  = '{0,   5,   6,    905, 0,  1'b0, 16'h0000, 2};
        tab[6]  = '{100, 700, 750,  906, 20, 1'b1, 16'h0000, 67};
        tab[7]  = '{64,  20,  30,   907, 31, 1'b1, 16'h0000, 67};
        tab[8]  = '{127, 90,  850,  908, 12, 1'b1, 16'h0000, 67};
        tab[9]  = '{2,   310, 400,  909, 0,  1'b0, 16'h8000, 5};
        tab[10] = '{2,   310, 400,  909, 16, 1'b0, 16'h8001, 5};

        rst            = 1'b0;
        ld_we          = 1'b0;
        ld_addr        = '0;
        ld_data        = '0;
        bus.start      = 1'b0;
        bus.cfg_ntaps  = '0;
        bus.cfg_x_base = '0;
        bus.cfg_h_base = '0;
        bus.cfg_y_addr = '0;
        bus.cfg_shift  = '0;
        repeat (3) @(negedge clk);
        check("reset outputs_zero", 32'(any_out()), 32'd0);

        for (int a = 0; a < 1024; a++) write_mem(a, $urandom);
        for (int k = 0; k < 4; k++) begin
            write_mem(100 + k, 32'(k + 1));
            write_mem(200 - k, 32'((k + 1) * 10));
        end
        write_mem(300, 32'h5A5A7FFF);
        write_mem(299, 32'h00007FFF);
        write_mem(400, 32'hFFFF7FFF);
        write_mem(401, 32'h12347FFF);
        write_mem(310, 32'hABCD8000);
        write_mem(309, 32'h00008000);
        write_mem(500, 32'h1234FFFF);
        write_mem(600, 32'hFFFF0064);
        @(negedge clk);
        ld_we = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("post_reset idle", 32'(any_out()), 32'd0);

        for (int i = 0; i < 11; i++) begin
            ey = tab[i].use_model ? ref_y(tab[i].n, tab[i].xb, tab[i].hb, tab[i].sh) : tab[i].exp_y;
            run_job($sformatf("vec%0d", i), tab[i].n, tab[i].xb, tab[i].hb, tab[i].ya,
                    tab[i].sh, ey, tab[i].exp_done, 1'b0);
        end

        // Extra start pulses and cfg churn mid-job must neither restart nor alter the job.
        ey = ref_y(8, 40, 60, 2);
        run_job("start_ignored", 8, 40, 60, 920, 2, ey, 11, 1'b1);
        ey = ref_y(3, 45, 65, 0);
        run_job("second_job", 3, 45, 65, 921, 0, ey, 6, 1'b0);

        reset_mid_job();
        ey = ref_y(8, 200, 100, 1);
        run_job("after_reset", 8, 200, 100, 910, 1, ey, 11, 1'b0);

        for (int j = 0; j < 25; j++) begin
            n  = $urandom_range(0, 80);
            xb = $urandom_range(0, 1023);
            hb = $urandom_range(0, 1023);
            ya = $urandom_range(0, 1023);
            sh = $urandom_range(0, 31);
            np = (n > 64) ? 64 : n;
            ey = ref_y(n, xb, hb, sh);
            run_job($sformatf("rand%0d", j), n, xb, hb, ya, sh, ey, (np == 0) ? 2 : np + 3, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
